// File: rtl/sa_array_ws.sv
// Weight-stationary systolic array: weights held per PE, activations flow right,
// partial sums flow down, with internal input skew and output deskew.
module sa_array_ws #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 32,
    parameter int NUM_ROWS      = 4,
    parameter int NUM_COLS      = 4,
    parameter int SIGNED        = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         i_w_valid,
    output logic                                         o_w_ready,
    input  logic [NUM_COLS-1:0][MUL_DATAWIDTH-1:0]       i_weight,
    input  logic                                         i_act_valid,
    output logic                                         o_act_ready,
    input  logic [NUM_ROWS-1:0][MUL_DATAWIDTH-1:0]       i_act,
    input  logic                                         i_psum_en,
    input  logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0]       i_psum,
    output logic                                         o_valid,
    output logic [NUM_COLS-1:0][ADD_DATAWIDTH-1:0]       o_psum,
    output logic                                         o_busy
);
    localparam int M  = MUL_DATAWIDTH;
    localparam int A  = ADD_DATAWIDTH;
    localparam int L  = NUM_ROWS + NUM_COLS;
    localparam int CW = $clog2(L + 1);
    localparam int BW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int EW = (A > 2 * M) ? A : 2 * M;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD_W  = 2'd1;
    localparam logic [1:0] COMPUTE = 2'd2;
    localparam logic [1:0] DRAIN   = 2'd3;

    // Full-width product, extended per operand signedness, then wrapped to A bits.
    function automatic logic [A-1:0] mul_ext(input logic [M-1:0] a, input logic [M-1:0] b);
        logic signed [2*M-1:0] sp;
        logic        [2*M-1:0] up;
        logic signed [EW-1:0]  se;
        logic        [EW-1:0]  ue;
        sp = $signed({{M{a[M-1]}}, a}) * $signed({{M{b[M-1]}}, b});
        up = {{M{1'b0}}, a} * {{M{1'b0}}, b};
        se = EW'(sp);
        ue = EW'(up);
        return (SIGNED != 0) ? se[A-1:0] : ue[A-1:0];
    endfunction

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q;
    logic          wl_q;
    logic [CW-1:0] cnt_q;
    logic [L-1:0]  vld_q;
    logic          o_valid_q;
    logic [NUM_COLS-1:0][A-1:0] o_psum_q;
    logic [M-1:0]  w_q [NUM_ROWS][NUM_COLS];
    logic [M-1:0]  a_q [NUM_ROWS][NUM_COLS];
    logic [A-1:0]  p_q [NUM_ROWS][NUM_COLS];
    logic [M-1:0]  a_sk  [NUM_ROWS];
    logic [A-1:0]  ps_sk [NUM_COLS];
    logic [A-1:0]  ds_out [NUM_COLS];
    logic          w_xfer, a_xfer, load_entry;

    assign o_w_ready   = (state_q == LOAD_W);
    assign o_act_ready = wl_q && (state_q == IDLE || state_q == COMPUTE);
    assign o_busy      = (state_q != IDLE);
    assign o_valid     = o_valid_q;
    assign o_psum      = o_psum_q;
    assign w_xfer      = i_w_valid && o_w_ready;
    assign a_xfer      = i_act_valid && o_act_ready;
    assign load_entry  = (state_d == LOAD_W) && (state_q != LOAD_W);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_w_valid)   state_d = a_xfer ? DRAIN : LOAD_W;
                else if (a_xfer) state_d = COMPUTE;
            end
            LOAD_W:  if (w_xfer && beat_q == BW'(NUM_ROWS - 1)) state_d = IDLE;
            COMPUTE: begin
                if (i_w_valid)                     state_d = DRAIN;
                else if (cnt_q == '0 && !a_xfer)   state_d = IDLE;
            end
            default: if (cnt_q == '0) state_d = LOAD_W;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wl_q    <= 1'b0;
            cnt_q   <= '0;
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++) w_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            if (load_entry) begin
                beat_q <= '0;
                wl_q   <= 1'b0;
            end else if (w_xfer) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q == BW'(NUM_ROWS - 1)) wl_q <= 1'b1;
            end
            if (w_xfer)
                for (int r = 0; r < NUM_ROWS; r++)
                    if (beat_q == BW'(r))
                        for (int c = 0; c < NUM_COLS; c++) w_q[r][c] <= i_weight[c];
            // Result leaves the count on the edge that raises o_valid.
            case ({a_xfer, vld_q[L-1]})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Row r activation delayed r cycles before entering column 0.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_skew
        if (r == 0) begin : g_pass
            assign a_sk[r] = i_act[r];
        end else begin : g_dly
            logic [M-1:0] sk_q [r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) sk_q[k] <= '0;
                end else begin
                    sk_q[0] <= i_act[r];
                    for (int k = 1; k < r; k++) sk_q[k] <= sk_q[k-1];
                end
            end
            assign a_sk[r] = sk_q[r-1];
        end
    end

    // Incoming psum for column c meets its activation wave c+1 cycles later.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_pskew
        logic [A-1:0] ps_q [c+1];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= c; k++) ps_q[k] <= '0;
            end else begin
                ps_q[0] <= i_psum_en ? i_psum[c] : '0;
                for (int k = 1; k <= c; k++) ps_q[k] <= ps_q[k-1];
            end
        end
        assign ps_sk[c] = ps_q[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++) begin
                    a_q[r][c] <= '0;
                    p_q[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                a_q[r][0] <= a_sk[r];
                for (int c = 1; c < NUM_COLS; c++) a_q[r][c] <= a_q[r][c-1];
            end
            for (int c = 0; c < NUM_COLS; c++) begin
                p_q[0][c] <= ps_sk[c] + mul_ext(a_q[0][c], w_q[0][c]);
                for (int r = 1; r < NUM_ROWS; r++)
                    p_q[r][c] <= p_q[r-1][c] + mul_ext(a_q[r][c], w_q[r][c]);
            end
        end
    end

    // Column c waits NUM_COLS-1-c cycles so all columns of a result align.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_deskew
        localparam int D = NUM_COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign ds_out[c] = p_q[NUM_ROWS-1][c];
        end else begin : g_dly
            logic [A-1:0] ds_q [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) ds_q[k] <= '0;
                end else begin
                    ds_q[0] <= p_q[NUM_ROWS-1][c];
                    for (int k = 1; k < D; k++) ds_q[k] <= ds_q[k-1];
                end
            end
            assign ds_out[c] = ds_q[D-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            o_valid_q <= 1'b0;
            o_psum_q  <= '0;
        end else begin
            vld_q     <= {vld_q[L-2:0], a_xfer};
            o_valid_q <= vld_q[L-1];
            if (vld_q[L-1])
                for (int c = 0; c < NUM_COLS; c++) o_psum_q[c] <= ds_out[c];
        end
    end
endmodule

// File: tb/tb_sa_array_ws.sv
// Directed bench for sa_array_ws on a 2x2 grid; a second 8-bit-accumulator
// instance shares the stimulus to exercise modular wrap.
module tb_sa_array_ws;
    localparam int MW = 8, AW = 32, AW2 = 8, R = 2, C = 2, L = R + C;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  i_w_valid, i_act_valid, i_psum_en;
    logic [C-1:0][MW-1:0]  i_weight;
    logic [R-1:0][MW-1:0]  i_act;
    logic [C-1:0][AW-1:0]  i_psum, o_psum;
    logic [C-1:0][AW2-1:0] i_psum2, o_psum2;
    logic o_w_ready, o_act_ready, o_valid, o_busy;
    logic o_w_ready2, o_act_ready2, o_valid2, o_busy2;

    assign i_psum2[0] = i_psum[0][AW2-1:0];
    assign i_psum2[1] = i_psum[1][AW2-1:0];

    sa_array_ws #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW), .NUM_ROWS(R), .NUM_COLS(C), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready), .i_weight(i_weight),
        .i_act_valid(i_act_valid), .o_act_ready(o_act_ready), .i_act(i_act), .i_psum_en(i_psum_en),
        .i_psum(i_psum), .o_valid(o_valid), .o_psum(o_psum), .o_busy(o_busy));

    sa_array_ws #(.MUL_DATAWIDTH(MW), .ADD_DATAWIDTH(AW2), .NUM_ROWS(R), .NUM_COLS(C), .SIGNED(1)) dut8 (
        .clk(clk), .rst(rst), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready2), .i_weight(i_weight),
        .i_act_valid(i_act_valid), .o_act_ready(o_act_ready2), .i_act(i_act), .i_psum_en(i_psum_en),
        .i_psum(i_psum2), .o_valid(o_valid2), .o_psum(o_psum2), .o_busy(o_busy2));

    int n_cmp = 0, n_err = 0;
    int va [3][2];
    int ve [3][2];

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_act(input int a0, input int a1);
        i_act[0] = 8'(a0);
        i_act[1] = 8'(a1);
    endtask

    task automatic set_w(input int w0, input int w1);
        i_weight[0] = 8'(w0);
        i_weight[1] = 8'(w1);
    endtask

    task automatic load_w(input int w00, input int w01, input int w10, input int w11);
        int k;
        i_w_valid = 1'b1;
        set_w(w00, w01);
        k = 0;
        while (!o_w_ready && k < 20) begin
            step();
            k++;
        end
        chk("w_ready_wait", int'(o_w_ready), 1);
        step();
        set_w(w10, w11);
        step();
        i_w_valid = 1'b0;
        chk("act_ready_after_load", int'(o_act_ready), 1);
    endtask

    // n activations back-to-back from va[], results expected in ve[].
    task automatic burst(input int n, input logic en, input int p0, input int p1);
        logic exp_v;
        for (int k = 0; k < n + L + 2; k++) begin
            if (k < n) begin
                chk("act_ready", int'(o_act_ready), 1);
                i_act_valid = 1'b1;
                set_act(va[k][0], va[k][1]);
                i_psum_en = en;
                i_psum[0] = 32'(p0);
                i_psum[1] = 32'(p1);
            end else begin
                i_act_valid = 1'b0;
            end
            step();
            exp_v = (k >= L) && (k - L < n);
            chk("o_valid", int'(o_valid), int'(exp_v));
            chk("o_valid8", int'(o_valid2), int'(exp_v));
            if (exp_v) begin
                chk("psum0", int'(o_psum[0]), ve[k-L][0]);
                chk("psum1", int'(o_psum[1]), ve[k-L][1]);
                chk("psum8_0", int'(o_psum2[0]), ve[k-L][0] & 255);
                chk("psum8_1", int'(o_psum2[1]), ve[k-L][1] & 255);
            end
        end
        chk("psum_hold", int'(o_psum[0]), ve[n-1][0]);
        chk("idle_after_burst", int'(o_busy), 0);
        i_psum_en = 1'b0;
    endtask

    // Activation then weight request (same cycle when lag==0, next cycle otherwise).
    task automatic reload_busy(input int lag, input int a0, input int a1, input int e0, input int e1,
                               input int w00, input int w01, input int w10, input int w11);
        int k, kv, kr;
        i_act_valid = 1'b1;
        set_act(a0, a1);
        i_psum_en = 1'b0;
        if (lag == 0) begin
            i_w_valid = 1'b1;
            set_w(w00, w01);
        end
        step();
        k = 0;
        i_act_valid = 1'b0;
        i_w_valid = 1'b1;
        set_w(w00, w01);
        if (lag != 0) begin
            step();
            k = 1;
        end
        chk("drain_act_ready", int'(o_act_ready), 0);
        chk("drain_w_ready", int'(o_w_ready), 0);
        chk("drain_busy", int'(o_busy), 1);
        kv = -1;
        kr = -1;
        while (kr < 0 && k < 12) begin
            step();
            k++;
            if (o_valid) begin
                kv = k;
                chk("drain_psum0", int'(o_psum[0]), e0);
                chk("drain_psum1", int'(o_psum[1]), e1);
                chk("w_ready_at_result", int'(o_w_ready), 0);
            end
            if (o_w_ready) kr = k;
        end
        chk("drain_valid_cycle", kv, L);
        chk("drain_ready_cycle", kr, L + 1);
        step();
        chk("loadw_act_ready", int'(o_act_ready), 0);
        set_w(w10, w11);
        step();
        i_w_valid = 1'b0;
        chk("reload_act_ready", int'(o_act_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_w_valid = 1'b0;
        i_act_valid = 1'b0;
        i_psum_en = 1'b0;
        i_weight = '0;
        i_act = '0;
        i_psum = '0;
        step();
        step();
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_psum", int'(o_psum[0]), 0);
        chk("rst_w_ready", int'(o_w_ready), 0);
        chk("rst_act_ready", int'(o_act_ready), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst8_outs", int'({o_w_ready2, o_act_ready2, o_busy2}), 0);
        rst = 1'b0;
        step();
        chk("no_weights_act_ready", int'(o_act_ready), 0);

        load_w(1, 2, 3, 4);

        va[0] = '{5, 6}; ve[0] = '{23, 34};
        burst(1, 1'b0, 0, 0);

        va[0] = '{1, 1}; ve[0] = '{4, 6};
        va[1] = '{2, 0}; ve[1] = '{2, 4};
        va[2] = '{0, 3}; ve[2] = '{9, 12};
        burst(3, 1'b0, 0, 0);

        va[0] = '{5, 6}; ve[0] = '{123, 234};
        burst(1, 1'b1, 100, 200);

        reload_busy(1, 5, 6, 23, 34, 1, 0, 0, 1);
        va[0] = '{7, 9}; ve[0] = '{7, 9};
        burst(1, 1'b0, 0, 0);

        reload_busy(0, 1, 1, 1, 1, 255, 255, 255, 255);
        va[0] = '{128, 128}; ve[0] = '{256, 256};
        burst(1, 1'b0, 0, 0);

        // Reset two cycles after an accepted activation.
        i_act_valid = 1'b1;
        set_act(5, 6);
        step();
        i_act_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_act_ready", int'(o_act_ready), 0);
        step();
        rst = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            step();
            chk("midrst_no_valid", int'(o_valid | o_valid2), 0);
        end
        i_act_valid = 1'b1;
        chk("midrst_act_blocked", int'(o_act_ready), 0);
        step();
        i_act_valid = 1'b0;
        chk("midrst_still_idle", int'(o_busy), 0);
        load_w(1, 2, 3, 4);
        va[0] = '{5, 6}; ve[0] = '{23, 34};
        burst(1, 1'b0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
